mac_result_drain: RTL and testbench

- Receiving end of the dual 8-bit MAC (c5_mac_8bitx2). Sits beside the MAC and tracks each operand beat issued to it.
- Aligns the MAC's registered result with the issuing beat's valid/last tags and accumulates results over a variable-length group.
- Writes each completed, saturated sum into an output FIFO with a valid/ready handshake.
- Back-pressures the operand issuer so that no in-flight result is ever dropped.

---
 rtl/mac_result_drain.sv | 208 ++++++++++++++++++++
 tb/tb_mac_result_drain.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_drain.sv
// mac_result_drain
// ----------------
// Receiving end of the dual 8-bit MAC. The block tracks every operand beat
// handed to the MAC, lines the MAC's registered result up with that beat's
// valid/last tags, and accumulates the results over a variable-length group.
// Each finished group sum is saturated to the signed ACC_W range and written
// into a small output FIFO. The issuer is back-pressured so that a group sum
// that is already in flight always has a free FIFO slot when it arrives.
//
// Ports
//   clock          rising-edge clock, shared with the MAC
//   resetn         synchronous active-low reset
//   issue_valid    operands are presented to the MAC this cycle
//   issue_last     this beat closes the current group (only with issue_valid)
//   issue_ready    issuer may assert issue_valid this cycle
//   mac_result     MAC result, valid MAC_LATENCY cycles after its issue
//   out_valid      FIFO head holds a completed sum
//   out_data       FIFO head value (0 when the FIFO is empty)
//   out_ready      consumer accepts the head this cycle
//   overflow_flag  sticky; set once any group has saturated
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. On the issue side the block never takes a beat while issue_ready is
// 0, and issue_ready may depend combinationally on out_ready. On the output
// side out_valid/out_data are stable until the edge on which out_ready is 1.

module mac_result_drain #(
  parameter int IN_W        = 32,
  parameter int ACC_W       = 32,
  parameter int MAC_LATENCY = 2,
  parameter int OUT_DEPTH   = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             issue_valid,
  input  logic             issue_last,
  output logic             issue_ready,
  input  logic [IN_W-1:0]  mac_result,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready,
  output logic             overflow_flag
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int IF_W  = $clog2(MAC_LATENCY + 1);
  localparam int SUM_W = CNT_W + IF_W;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  // Tag delay line; index MAC_LATENCY-1 is the tail that qualifies
  // mac_result in the current cycle.
  logic [MAC_LATENCY-1:0] tag_v;
  logic [MAC_LATENCY-1:0] tag_l;

  // Goes high on the first edge after reset is released, so issue_ready
  // stays low for the whole reset and rises one cycle later.
  logic                   run;

  logic [ACC_W-1:0]       acc;
  logic                   first;
  logic                   grp_sat;

  logic [ACC_W-1:0]       mem [OUT_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  // ---------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------
  logic                   dv;
  logic                   dl;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic [IF_W-1:0]        inflight;
  logic [SUM_W-1:0]       credit;
  logic [SUM_W-1:0]       depth_s;

  logic [ACC_W:0]         ext;
  logic [ACC_W:0]         base;
  logic [ACC_W:0]         sum;
  logic                   clamp_hi;
  logic                   clamp_lo;
  logic                   clamped;
  logic [ACC_W-1:0]       sat_val;

  assign dv     = tag_v[MAC_LATENCY-1];
  assign dl     = tag_l[MAC_LATENCY-1];
  assign accept = issue_valid & issue_ready;
  assign push   = dv & dl;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid & out_ready;
  assign full      = (count == CNT_W'(OUT_DEPTH));

  // Every valid last tag still in the delay line owns a future FIFO slot.
  // The tail tag is counted too: its push lands on this edge but is not yet
  // reflected in count, so count + inflight is the number of slots already
  // promised to accepted groups.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MAC_LATENCY; i++) begin
      inflight = inflight + IF_W'(tag_v[i] & tag_l[i]);
    end
  end

  assign credit  = SUM_W'(count) + SUM_W'(inflight);
  assign depth_s = SUM_W'(OUT_DEPTH);

  // One slot of headroom is recovered when the consumer pops this cycle,
  // which keeps full-rate streaming possible with a full FIFO.
  assign issue_ready = run &
                       ((credit < depth_s) | ((credit == depth_s) & pop));

  // Accumulate one extra bit wide so that a single add can never wrap;
  // the top two bits then tell directly which way the sum left the range.
  always_comb begin
    ext      = {{(ACC_W + 1 - IN_W){mac_result[IN_W-1]}}, mac_result};
    base     = first ? '0 : {acc[ACC_W-1], acc};
    sum      = base + ext;
    clamp_hi = ~sum[ACC_W] &  sum[ACC_W-1];
    clamp_lo =  sum[ACC_W] & ~sum[ACC_W-1];
    clamped  = 1'b0;
    sat_val  = sum[ACC_W-1:0];
    if (grp_sat) begin
      // Saturation is sticky within a group: hold the clamped value.
      sat_val = acc;
    end else if (clamp_hi) begin
      sat_val = {1'b0, {(ACC_W-1){1'b1}}};
      clamped = 1'b1;
    end else if (clamp_lo) begin
      sat_val = {1'b1, {(ACC_W-1){1'b0}}};
      clamped = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Control and accumulator registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      tag_v         <= '0;
      tag_l         <= '0;
      run           <= 1'b0;
      acc           <= '0;
      first         <= 1'b1;
      grp_sat       <= 1'b0;
      overflow_flag <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      run <= 1'b1;

      for (int i = 1; i < MAC_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
      tag_v[0] <= accept;
      tag_l[0] <= issue_last;

      if (dv) begin
        if (clamped) begin
          overflow_flag <= 1'b1;
        end
        if (dl) begin
          acc     <= '0;
          first   <= 1'b1;
          grp_sat <= 1'b0;
        end else begin
          acc     <= sat_val;
          first   <= 1'b0;
          grp_sat <= grp_sat | clamped;
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // The credit scheme reserves a slot for every in-flight group sum,
      // so a push into a full FIFO means the reservation was broken.
      assert (!(push && full));
    end
  end

  // FIFO storage carries no reset; out_data is masked to 0 while empty.
  always_ff @(posedge clock) begin
    if (resetn && push) begin
      mem[wr_ptr] <= sat_val;
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain. The bench plays the MAC: a value handed over
// with an accepted beat reappears on mac_result LAT cycles later. A reference
// model keeps the group sums as plain integers, the expected output words in
// a queue, and the cycle at which each word becomes visible.

module tb_mac_result_drain;

  localparam int     LAT  = 2;
  localparam int     D    = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam int     NEVER = 2147483647;

  logic        clock = 1'b0;
  logic        resetn;
  logic        issue_valid;
  logic        issue_last;
  logic        issue_ready;
  logic [31:0] mac_result;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        overflow_flag;

  mac_result_drain #(
    .IN_W(32), .ACC_W(32), .MAC_LATENCY(LAT), .OUT_DEPTH(D)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .issue_valid   (issue_valid),
    .issue_last    (issue_last),
    .issue_ready   (issue_ready),
    .mac_result    (mac_result),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .overflow_flag (overflow_flag)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard / model state ----------------
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          ready_en = 1'b0;
  logic [31:0] sched [0:255];
  logic [31:0] exp_q [$];
  int          vis_q [$];
  longint      grp_sum = 0;
  bit          grp_sat = 1'b0;
  int          ovf_time = NEVER;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Adds one accepted beat to the running group of the reference model.
  task automatic model_beat(input logic [31:0] val, input bit il);
    longint s;
    if (!grp_sat) begin
      s = grp_sum + longint'($signed(val));
      if (s > MAXV) begin
        s = MAXV;
        grp_sat = 1'b1;
      end else if (s < MINV) begin
        s = MINV;
        grp_sat = 1'b1;
      end
      if (grp_sat && (cyc + LAT + 1 < ovf_time)) ovf_time = cyc + LAT + 1;
      grp_sum = s;
    end
    if (il) begin
      exp_q.push_back(grp_sum[31:0]);
      vis_q.push_back(cyc + LAT + 1);
      grp_sum = 0;
      grp_sat = 1'b0;
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit rn, input bit iv, input bit il,
                       input logic [31:0] val, input bit ordy);
    bit          ev;
    bit          er;
    bit          pop;
    logic [31:0] ed;
    resetn      = rn;
    issue_valid = iv;
    issue_last  = il;
    out_ready   = ordy;
    mac_result  = sched[cyc % 256];
    ev  = (vis_q.size() > 0) && (vis_q[0] <= cyc);
    ed  = ev ? exp_q[0] : 32'h0;
    pop = ev && ordy;
    er  = ready_en && ((exp_q.size() < D) || (exp_q.size() == D && pop));
    #4;
    if (chk_en) begin
      chk("issue_ready", {31'b0, issue_ready}, {31'b0, er});
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      chk("out_data", out_data, ed);
      chk("overflow_flag", {31'b0, overflow_flag}, {31'b0, (cyc >= ovf_time)});
    end
    if (iv && er) begin
      sched[(cyc + LAT) % 256] = val;
      model_beat(val, il);
    end
    if (pop) begin
      void'(exp_q.pop_front());
      void'(vis_q.pop_front());
    end
    @(posedge clock);
    #1;
    if (!rn) begin
      exp_q.delete();
      vis_q.delete();
      grp_sum  = 0;
      grp_sat  = 1'b0;
      ovf_time = NEVER;
      chk_en   = 1'b1;
    end
    ready_en = rn;
    cyc++;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, ordy);
  endtask

  function automatic logic [31:0] rnd_val();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return $urandom;
    if (sel == 1) return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
    return 32'($urandom_range(0, 200)) - 32'd100;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) sched[i] = 32'h0;
    resetn = 1'b0; issue_valid = 1'b0; issue_last = 1'b0;
    out_ready = 1'b0; mac_result = 32'h0;

    // reset, then issue_ready must come up one cycle after release
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2, 1'b0);

    // basic group 2,2,2 -> 6 three cycles after the last issue
    cycle(1'b1, 1'b1, 1'b0, 32'd2, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd2, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'd2, 1'b0);
    idle(2, 1'b0);
    chk("basic_sum", out_data, 32'd6);
    idle(3, 1'b1);

    // single-beat groups, FIFO fills and issue_ready drops
    cycle(1'b1, 1'b1, 1'b1, 32'd1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'd5, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'd9, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'd9, 1'b0);
    idle(6, 1'b1);

    // back-pressure: stream last beats with the consumer stalled
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b1, rnd_val(), 1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, rnd_val(), 1'b0);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // saturation, positive and negative, then a clean group
    cycle(1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'd1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'd1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'd1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'd1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1);
    idle(4, 1'b1);
    chk("ovf_sticky", {31'b0, overflow_flag}, 32'd1);

    // bubbles, and a push/pop in the same cycle with one entry held
    cycle(1'b1, 1'b1, 1'b1, 32'd7, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd10, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'd20, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    chk("bubble_sum", out_data, 32'd30);
    idle(3, 1'b1);

    // reset one cycle after a last beat: the sum must never appear
    cycle(1'b1, 1'b1, 1'b1, 32'd55, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(4, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd4, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'd4, 1'b0);
    idle(2, 1'b0);
    chk("post_reset_sum", out_data, 32'd8);
    idle(3, 1'b1);

    // randomized traffic with one reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      end else begin
        cycle(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
              rnd_val(), ($urandom_range(0, 2) != 0));
      end
    end
    idle(10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
